// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared widths and FSM state encodings for the divider controller
package div_ctrl_pkg;

  localparam int DIV_DATA_WD = 32;
  localparam int DIV_CNT_WD  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_core
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WD = DIV_DATA_WD
) (
  input  logic [DATA_WD-1:0] r_in,
  input  logic [DATA_WD-1:0] q_in,
  input  logic [DATA_WD-1:0] divisor,
  input  logic               dividend_bit,
  output logic [DATA_WD-1:0] r_out,
  output logic [DATA_WD-1:0] q_out
);

  logic [DATA_WD:0] r_sh;
  logic [DATA_WD:0] diff;

  // Keep the subtraction only when the shifted partial remainder covers the divisor.
  always_comb begin
    r_sh = {r_in, dividend_bit};
    diff = r_sh - {1'b0, divisor};
    if (r_sh >= {1'b0, divisor}) begin
      r_out = diff[DATA_WD-1:0];
      q_out = {q_in[DATA_WD-2:0], 1'b1};
    end else begin
      r_out = r_sh[DATA_WD-1:0];
      q_out = {q_in[DATA_WD-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU sequencer with pipeline stall; DIV_ZERO_FAST_EN enables the divide-by-zero shortcut
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WD = DIV_DATA_WD,
  parameter int CNT_WD  = DIV_CNT_WD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 annul,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [DATA_WD-1:0]   div_opa,
  input  logic [DATA_WD-1:0]   div_opb,
  output logic                 stallreq_for_div,
  output logic                 div_ready,
  output logic [2*DATA_WD-1:0] div_result,
  output logic                 div_busy
);

  localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(DATA_WD - 1);

  div_state_e         state;
  logic [CNT_WD-1:0]  cnt;
  logic [DATA_WD-1:0] a_sh;
  logic [DATA_WD-1:0] b_abs;
  logic [DATA_WD-1:0] r_q;
  logic [DATA_WD-1:0] q_q;
  logic               sign_q;
  logic               sign_r;
  logic               b_zero;
  logic [DATA_WD-1:0] r_nxt;
  logic [DATA_WD-1:0] q_nxt;

  function automatic logic [DATA_WD-1:0] abs_of(input logic [DATA_WD-1:0] x, input logic sgn);
    return (sgn && x[DATA_WD-1]) ? -x : x;
  endfunction

  function automatic logic [DATA_WD-1:0] neg_if(input logic [DATA_WD-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // The dividend is consumed MSB-first by shifting a_sh left each BUSY cycle.
  div_core #(.DATA_WD(DATA_WD)) u_core (
    .r_in         (r_q),
    .q_in         (q_q),
    .divisor      (b_abs),
    .dividend_bit (a_sh[DATA_WD-1]),
    .r_out        (r_nxt),
    .q_out        (q_nxt)
  );

  // FSM, iteration counter, operand/sign latches and the registered result with sign fixup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_abs      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      b_zero     <= 1'b0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else begin
      div_ready <= 1'b0;
      if (annul) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (div_start) begin
              a_sh   <= abs_of(div_opa, div_signed);
              b_abs  <= abs_of(div_opb, div_signed);
              sign_q <= div_signed & (div_opa[DATA_WD-1] ^ div_opb[DATA_WD-1]);
              sign_r <= div_signed & div_opa[DATA_WD-1];
              b_zero <= (div_opb == '0);
              r_q    <= '0;
              q_q    <= '0;
              cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
              state  <= (div_opb == '0) ? DIV_ZERO : DIV_BUSY;
`else
              state  <= DIV_BUSY;
`endif
            end
          end
          DIV_BUSY: begin
            r_q  <= r_nxt;
            q_q  <= q_nxt;
            a_sh <= a_sh << 1;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state     <= DIV_DONE;
              div_ready <= 1'b1;
              // With a zero divisor r_nxt is |opa|, so the remainder fixup restores raw opa.
              div_result <= {neg_if(r_nxt, sign_r), b_zero ? {DATA_WD{1'b1}} : neg_if(q_nxt, sign_q)};
            end
          end
          DIV_ZERO: begin
            state      <= DIV_DONE;
            div_ready  <= 1'b1;
            div_result <= {neg_if(a_sh, sign_r), {DATA_WD{1'b1}}};
          end
          DIV_DONE: begin
            state <= DIV_IDLE;
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

  // Stall EX while an op is being accepted or computed; release it in DONE so EX advances.
  always_comb begin
    stallreq_for_div = 1'b0;
    case (state)
      DIV_IDLE: stallreq_for_div = div_start & ~annul;
      DIV_BUSY: stallreq_for_div = 1'b1;
      DIV_ZERO: stallreq_for_div = 1'b1;
      default:  stallreq_for_div = 1'b0;
    endcase
  end

  assign div_busy = (state != DIV_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl with a cycle-level behavioural model
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        annul;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        stallreq_for_div;
  logic        div_ready;
  logic [63:0] div_result;
  logic        div_busy;

  localparam int LAT = 33;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  div_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .annul            (annul),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_opa          (div_opa),
    .div_opb          (div_opb),
    .stallreq_for_div (stallreq_for_div),
    .div_ready        (div_ready),
    .div_result       (div_result),
    .div_busy         (div_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference result from plain integer division (truncating toward zero).
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: an accepted op at cycle T is in flight for cycles T+1..T+lat, ready at T+lat.
  bit          chk_en   = 1'b0;
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_lat    = 0;
  logic [63:0] m_res    = '0;
  logic [63:0] m_last   = '0;
  int          n_ready  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_ready, e_stall, e_busy;
      int   age;
      age     = cyc - m_start;
      e_ready = m_active && (age == m_lat);
      e_busy  = m_active;
      e_stall = m_active ? (age < m_lat) : (div_start & ~annul);
      if (e_ready) m_last = m_res;
      chk("cyc_ready",  64'(div_ready),        64'(e_ready));
      chk("cyc_stall",  64'(stallreq_for_div), 64'(e_stall));
      chk("cyc_busy",   64'(div_busy),         64'(e_busy));
      chk("cyc_result", div_result,            m_last);
      if (div_ready === 1'b1) n_ready++;
      if (rst) begin
        m_active = 1'b0;
        m_last   = '0;
      end else if (annul) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (age == m_lat) m_active = 1'b0;
      end else if (div_start) begin
        m_active = 1'b1;
        m_start  = cyc;
        m_res    = ref_div(div_signed, div_opa, div_opb);
        m_lat    = (div_opb == 32'd0) ? ZLAT : LAT;
      end
    end
  end

  task automatic wait_ready(output int rc, output logic [63:0] res);
    rc  = -1;
    res = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (div_ready === 1'b1) begin
        rc  = cyc;
        res = div_result;
        break;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [63:0] exp);
    int t, rc;
    logic [63:0] res;
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = sgn;
    div_opa    = a;
    div_opb    = b;
    t          = cyc;
    wait_ready(rc, res);
    chk({nm, "_lat"}, 64'(longint'(rc - t)), 64'(longint'(lat)));
    chk({nm, "_res"}, res, exp);
    @(posedge clk); #1;
    div_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rc, rc2, n0;
    logic [63:0] res, res2;
    rst = 1'b1; annul = 1'b0; div_start = 1'b0; div_signed = 1'b0;
    div_opa = '0; div_opb = '0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready",  64'(div_ready),        64'd0);
    chk("rst_stall",  64'(stallreq_for_div), 64'd0);
    chk("rst_busy",   64'(div_busy),         64'd0);
    chk("rst_result", div_result,            64'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_op("divu_100_7", 1'b0, 32'd100,        32'd7,          LAT,  {32'd2,        32'd14});
    do_op("div_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          LAT,  {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_op("div_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   LAT,  {32'd1,        32'hFFFFFFFD});
    do_op("div_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   LAT,  {32'd0,        32'h80000000});
    do_op("divu_5_0",   1'b0, 32'd5,          32'd0,          ZLAT, {32'd5,        32'hFFFFFFFF});
    do_op("div_m5_0",   1'b1, 32'hFFFFFFFB,   32'd0,          ZLAT, {32'hFFFFFFFB, 32'hFFFFFFFF});
    do_op("divu_big",   1'b0, 32'hFFFFFFFF,   32'h10,         LAT,  {32'hF,        32'h0FFFFFFF});
    do_op("divu_3_5",   1'b0, 32'd3,          32'd5,          LAT,  {32'd3,        32'd0});

    // annul mid-BUSY, then restart two cycles later
    n0 = n_ready;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; div_opa = 32'd1000; div_opb = 32'd3;
    t = cyc;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; div_start = 1'b0;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_busy",  64'(div_busy),         64'd0);
    chk("annul_stall", 64'(stallreq_for_div), 64'd0);
    @(posedge clk); #1;
    div_start = 1'b1;
    wait_ready(rc, res);
    chk("annul_restart_cyc", 64'(longint'(rc - t)), 64'd45);
    chk("annul_restart_res", res, {32'd1, 32'd333});
    @(posedge clk); #1 div_start = 1'b0;
    chk("annul_pulses", 64'(longint'(n_ready - n0)), 64'd1);

    // back-to-back: start held through DONE, new operands in the following IDLE
    n0 = n_ready;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; div_opa = 32'd50; div_opb = 32'd6;
    t = cyc;
    wait_ready(rc, res);
    @(posedge clk); #1 div_opa = 32'd77; div_opb = 32'd10;
    wait_ready(rc2, res2);
    chk("b2b_lat1", 64'(longint'(rc - t)),    64'd33);
    chk("b2b_res1", res,                      {32'd2, 32'd8});
    chk("b2b_lat2", 64'(longint'(rc2 - rc)),  64'd34);
    chk("b2b_res2", res2,                     {32'd7, 32'd7});
    @(posedge clk); #1 div_start = 1'b0;
    repeat (3) @(posedge clk);
    chk("b2b_pulses", 64'(longint'(n_ready - n0)), 64'd2);

    // reset in BUSY
    n0 = n_ready;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b1; div_opa = 32'd123; div_opb = 32'd4;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; div_start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstb_ready",  64'(div_ready),        64'd0);
    chk("rstb_stall",  64'(stallreq_for_div), 64'd0);
    chk("rstb_busy",   64'(div_busy),         64'd0);
    chk("rstb_result", div_result,            64'd0);
    do_op("after_rst", 1'b1, 32'd123, 32'd4, LAT, {32'd3, 32'd30});
    chk("rstb_pulses", 64'(longint'(n_ready - n0)), 64'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
